// File: rtl/bpair_pkg.sv
// Shared sizing helpers and entry layout for the bpair collector.
// BPAIR_COLLECTOR_PARITY_EN adds a stored parity bit to every FIFO entry.
package bpair_pkg;

    function automatic int f_clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) r++;
        return r;
    endfunction

    // An index register is never narrower than one bit, even when it only counts to one.
    function automatic int f_idx_w(input int n);
        return (n <= 2) ? 1 : f_clog2(n);
    endfunction

    localparam int WORD_W_DEF = 8;
    localparam int DEPTH_DEF  = 4;
    localparam int PAIRS_DEF  = WORD_W_DEF / 2;
    localparam int PTR_W_DEF  = f_clog2(DEPTH_DEF);

`ifdef BPAIR_COLLECTOR_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
    typedef struct packed {
        logic                  parity;
        logic [WORD_W_DEF-1:0] word;
    } entry_t;
`else
    localparam bit PARITY_EN = 1'b0;
    typedef struct packed {
        logic [WORD_W_DEF-1:0] word;
    } entry_t;
`endif

    function automatic int f_entry_w(input int word_w);
        return word_w + (PARITY_EN ? 1 : 0);
    endfunction

endpackage

// File: rtl/bpair_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted only when a pop happens in the same cycle.
import bpair_pkg::*;

module bpair_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = f_clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign empty     = (r_count == '0);
    assign full      = (r_count == CNT_W'(DEPTH));
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign head      = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: storage has no reset; empty gates head to zero, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/bpair_collector.sv
// Packs sampled (in_b1, in_b2) pairs into WORD_W-bit words and queues them for a valid/ready consumer.
// Optional BPAIR_COLLECTOR_PARITY_EN stores per-word parity and exposes it on out_parity.
import bpair_pkg::*;

module bpair_collector #(
    parameter int WORD_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_b1,
    input  logic              in_b2,
    input  logic              sample_en,
    input  logic              flush,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overflow
`ifdef BPAIR_COLLECTOR_PARITY_EN
    ,
    output logic              out_parity
`endif
);

    localparam int PAIRS   = WORD_W / 2;
    localparam int PCNT_W  = f_idx_w(PAIRS);
    localparam int ENTRY_W = f_entry_w(WORD_W);

    logic [PCNT_W-1:0]  r_pcnt;
    logic [WORD_W-1:0]  r_partial;
    logic               r_overflow;

    logic [WORD_W-1:0]  w_next_partial;
    logic               w_last;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [ENTRY_W-1:0] w_din;
    logic [ENTRY_W-1:0] w_head;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        w_next_partial = r_partial;
        for (int k = 0; k < PAIRS; k++) begin
            if (r_pcnt == PCNT_W'(k)) begin
                w_next_partial[2*k+1] = in_b1;
                w_next_partial[2*k]   = in_b2;
            end
        end
    end

    assign w_last    = (r_pcnt == PCNT_W'(PAIRS - 1));
    assign w_push    = sample_en && w_last && !flush;
    assign out_valid = !w_empty;
    assign w_pop     = out_valid && out_ready;

`ifdef BPAIR_COLLECTOR_PARITY_EN
    assign w_din      = {^w_next_partial, w_next_partial};
    assign out_parity = w_head[WORD_W];
`else
    assign w_din      = w_next_partial;
`endif
    assign out_data   = w_head[WORD_W-1:0];
    assign overflow   = r_overflow;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pcnt     <= '0;
            r_partial  <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_pcnt     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (sample_en) begin
                r_partial <= w_next_partial;
                r_pcnt    <= w_last ? '0 : r_pcnt + PCNT_W'(1);
            end
            // A word is lost only when the FIFO is full and nothing leaves this cycle.
            if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
        end
    end

    bpair_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_din),
        .full  (w_full),
        .empty (w_empty),
        .head  (w_head)
    );

endmodule
